// File: rtl/fft64_out_serializer.sv
// fft64_out_serializer
// Ping-pong unloader for the 64-point FFT core. A full spectrum is captured
// in one handshake into the free buffer, then streamed one complex sample
// per cycle in natural order (X[0]..X[63]) with valid/ready flow control.
// The second buffer lets the next frame land while the current one drains,
// so back-to-back frames come out with no bubble.
module fft64_out_serializer #(
  parameter int N     = 64,
  parameter int W     = 34,
  parameter int IDX_W = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N*W-1:0]   par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_last,
  output logic [15:0]      frame_cnt
);

  // Frame storage; contents are don't-care until the matching full flag is set
  logic [N*W-1:0]   buf0_q;
  logic [N*W-1:0]   buf1_q;

  // Control state
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic             wr_sel_q;
  logic             wr_sel_d;
  logic             rd_sel_q;
  logic             rd_sel_d;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] rd_idx_d;
  logic [15:0]      frame_cnt_q;
  logic [15:0]      frame_cnt_d;

  // Decoded strobes
  logic             capture_s;
  logic             xfer_s;
  logic             at_last_s;
  logic             rd_valid_s;
  logic [N*W-1:0]   rd_buf_s;
  logic [W-1:0]     lanes_s [N];

  // Write side is ready purely from registered state: the target buffer is empty
  assign par_ready  = ~full_q[wr_sel_q];
  assign capture_s  = par_valid & par_ready;

  assign rd_valid_s = full_q[rd_sel_q];
  assign xfer_s     = rd_valid_s & out_ready;
  assign at_last_s  = (rd_idx_q == IDX_W'(N - 1));

  // Split the buffer being drained into per-sample lanes for the index mux
  assign rd_buf_s = rd_sel_q ? buf1_q : buf0_q;
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lanes_s[g] = rd_buf_s[g*W +: W];
  end

  assign out_valid = rd_valid_s;
  assign out_data  = rd_valid_s ? lanes_s[rd_idx_q] : {W{1'b0}};
  assign out_idx   = rd_idx_q;
  assign out_sof   = rd_valid_s & (rd_idx_q == {IDX_W{1'b0}});
  assign out_last  = rd_valid_s & at_last_s;
  assign frame_cnt = frame_cnt_q;

  // Next-state for flags, pointers and drained-frame counter. A capture and a
  // frame-end drain in the same cycle always hit different buffers, because a
  // capture needs an empty target while a drain needs a full one.
  always_comb begin
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    rd_idx_d    = rd_idx_q;
    frame_cnt_d = frame_cnt_q;
    if (capture_s) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end else begin
      wr_sel_d = wr_sel_q;
    end
    if (xfer_s) begin
      if (at_last_s) begin
        rd_idx_d         = {IDX_W{1'b0}};
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        frame_cnt_d      = frame_cnt_q + 16'd1;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end else begin
      rd_idx_d = rd_idx_q;
    end
  end

  // Control registers; reset discards any partial or pending frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      full_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_idx_q    <= {IDX_W{1'b0}};
      frame_cnt_q <= 16'd0;
    end else begin
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      rd_idx_q    <= rd_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Frame capture into the selected buffer; data path needs no reset
  always_ff @(posedge sys_clk) begin
    if (capture_s && !wr_sel_q) begin
      buf0_q <= par_data;
    end else begin
      buf0_q <= buf0_q;
    end
    if (capture_s && wr_sel_q) begin
      buf1_q <= par_data;
    end else begin
      buf1_q <= buf1_q;
    end
  end

endmodule

// File: tb/tb_fft64_out_serializer.sv
// Bench for fft64_out_serializer: a negedge monitor keeps an occupancy model
// and a sample scoreboard fed from the frames the bench drives; a table of
// single-frame vectors plus hand-written multi-frame sequences drive it.
module tb_fft64_out_serializer;

  localparam int N     = 64;
  localparam int W     = 34;
  localparam int IDX_W = 6;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [N*W-1:0]   par_data;
  logic             par_valid;
  logic             par_ready;
  logic [W-1:0]     out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_last;
  logic [15:0]      frame_cnt;

  fft64_out_serializer dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [IDX_W-1:0] idx;
  } smp_t;

  typedef struct {
    int         seed;
    logic [3:0] rdy_pat;
    int         exp_hs;
    int         exp_sof;
    int         exp_last;
    int         exp_cnt_inc;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  smp_t        sb_q[$];
  int          cap_cyc_q[$];
  int          end_cyc_q[$];
  int          sof_cyc_q[$];
  int          occ = 0;
  int          drained = 0;
  int          cap_cnt = 0;
  int          hs_cnt = 0;
  int          sof_cnt = 0;
  int          last_cnt = 0;
  int          cyc = 0;
  logic [15:0] cnt_base = 16'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout, got no event expected one (t=%0t)", nm, $time);
  endtask

  function automatic logic [N*W-1:0] mk_frame(input int seed);
    logic [N*W-1:0] f;
    logic [16:0]    re;
    logic [16:0]    im;
    f = '0;
    for (int k = 0; k < N; k++) begin
      if (seed == 0) begin
        re = 17'(k);
        im = 17'(-k);
      end else begin
        re = 17'($urandom);
        im = 17'($urandom);
      end
      f[k*W +: W] = {re, im};
    end
    return f;
  endfunction

  // Monitor / scoreboard: compares DUT outputs against the occupancy model
  always @(negedge sys_clk) begin
    smp_t e;
    logic rdy_m;
    cyc = cyc + 1;
    if (!sys_rst_n) begin
      sb_q.delete();
      cap_cyc_q.delete();
      end_cyc_q.delete();
      sof_cyc_q.delete();
      occ = 0; drained = 0; cap_cnt = 0;
      hs_cnt = 0; sof_cnt = 0; last_cnt = 0;
      chk("rst_par_ready", 64'(par_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data",  64'(out_data),  64'(0));
      chk("rst_out_idx",   64'(out_idx),   64'(0));
      chk("rst_out_sof",   64'(out_sof),   64'(0));
      chk("rst_out_last",  64'(out_last),  64'(0));
      chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    end else begin
      rdy_m = (occ < 2);
      chk("par_ready", 64'(par_ready), 64'(rdy_m));
      chk("out_valid", 64'(out_valid), 64'(occ > 0));
      chk("frame_cnt", 64'(frame_cnt), 64'(16'(cnt_base + 16'(drained))));
      if (occ > 0) begin
        if (sb_q.size() == 0) begin
          timeout("sb_empty");
        end else begin
          e = sb_q[0];
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_idx",  64'(out_idx),  64'(e.idx));
          chk("out_sof",  64'(out_sof),  64'(e.idx == 6'd0));
          chk("out_last", 64'(out_last), 64'(e.idx == 6'd63));
          if (out_ready) begin
            void'(sb_q.pop_front());
            hs_cnt++;
            if (e.idx == 6'd0) begin
              sof_cnt++;
              sof_cyc_q.push_back(cyc);
            end
            if (e.idx == 6'd63) begin
              last_cnt++;
              occ--;
              drained++;
              end_cyc_q.push_back(cyc);
            end
          end
        end
      end else begin
        chk("idle_data", 64'(out_data), 64'(0));
        chk("idle_idx",  64'(out_idx),  64'(0));
        chk("idle_sof",  64'(out_sof),  64'(0));
        chk("idle_last", 64'(out_last), 64'(0));
      end
      if (par_valid && rdy_m) begin
        for (int k = 0; k < N; k++) sb_q.push_back({par_data[k*W +: W], 6'(k)});
        occ++;
        cap_cnt++;
        cap_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    cnt_base  = 16'd0;
    par_valid = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk("async_par_ready", 64'(par_ready), 64'(1));
    chk("async_out_valid", 64'(out_valid), 64'(0));
    chk("async_out_data",  64'(out_data),  64'(0));
    chk("async_out_idx",   64'(out_idx),   64'(0));
    chk("async_frame_cnt", 64'(frame_cnt), 64'(0));
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [N*W-1:0] f, input string nm);
    int c0;
    int t;
    c0 = cap_cnt;
    t = 0;
    par_data  = f;
    par_valid = 1'b1;
    while (cap_cnt == c0 && t < 300) begin
      @(posedge sys_clk); #1;
      t++;
    end
    par_valid = 1'b0;
    if (cap_cnt == c0) timeout(nm);
  endtask

  task automatic wait_drained(input int target, input logic [3:0] pat, input string nm);
    int i;
    i = 0;
    while (drained < target && i < 3000) begin
      out_ready = pat[i % 4];
      @(posedge sys_clk); #1;
      i++;
    end
    if (drained < target) timeout(nm);
  endtask

  vec_t        vecs[4];
  logic [15:0] exp_fc;

  initial begin
    int hs0, sof0, last0, t;
    vecs[0] = '{seed: 0,  rdy_pat: 4'b1111, exp_hs: 64, exp_sof: 1, exp_last: 1, exp_cnt_inc: 1};
    vecs[1] = '{seed: 11, rdy_pat: 4'b1001, exp_hs: 64, exp_sof: 1, exp_last: 1, exp_cnt_inc: 1};
    vecs[2] = '{seed: 12, rdy_pat: 4'b0101, exp_hs: 64, exp_sof: 1, exp_last: 1, exp_cnt_inc: 1};
    vecs[3] = '{seed: 13, rdy_pat: 4'b1110, exp_hs: 64, exp_sof: 1, exp_last: 1, exp_cnt_inc: 1};

    sys_rst_n = 1'b0;
    par_valid = 1'b0;
    par_data  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    exp_fc = 16'd0;

    // Table-driven single frames with assorted back-pressure patterns
    for (int i = 0; i < 4; i++) begin
      hs0 = hs_cnt; sof0 = sof_cnt; last0 = last_cnt;
      out_ready = vecs[i].rdy_pat[0];
      send_frame(mk_frame(vecs[i].seed), "vec_capture");
      if (vecs[i].seed == 0) begin
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("first_idx",   64'(out_idx),   64'(0));
        chk("first_sof",   64'(out_sof),   64'(1));
        chk("first_data",  64'(out_data),  64'(0));
        chk("first_ready", 64'(par_ready), 64'(1));
      end
      wait_drained(drained + 1, vecs[i].rdy_pat, "vec_drain");
      exp_fc = 16'(exp_fc + 16'(vecs[i].exp_cnt_inc));
      chk("vec_handshakes", 64'(hs_cnt - hs0),     64'(vecs[i].exp_hs));
      chk("vec_sof_count",  64'(sof_cnt - sof0),   64'(vecs[i].exp_sof));
      chk("vec_last_count", 64'(last_cnt - last0), 64'(vecs[i].exp_last));
      chk("vec_frame_cnt",  64'(frame_cnt),        64'(exp_fc));
      chk("vec_done_valid", 64'(out_valid),        64'(0));
    end

    // Back-to-back A, B, then C held until the first buffer frees
    do_reset();
    out_ready = 1'b1;
    par_data = mk_frame(21); par_valid = 1'b1;
    @(posedge sys_clk); #1;
    par_data = mk_frame(22);
    @(posedge sys_clk); #1;
    chk("b2b_ready_low", 64'(par_ready), 64'(0));
    par_data = mk_frame(23);
    t = 0;
    while (cap_cnt < 3 && t < 300) begin
      @(posedge sys_clk); #1;
      t++;
    end
    par_valid = 1'b0;
    if (cap_cnt < 3) timeout("b2b_capture_c");
    wait_drained(2, 4'b1111, "b2b_drain_b");
    chk("b2b_frame_cnt2", 64'(frame_cnt), 64'(2));
    wait_drained(3, 4'b1111, "b2b_drain_c");
    if (end_cyc_q.size() >= 1 && sof_cyc_q.size() >= 2 && cap_cyc_q.size() >= 3) begin
      chk("b2b_no_bubble", 64'(sof_cyc_q[1]), 64'(end_cyc_q[0] + 1));
      chk("b2b_c_capture", 64'(cap_cyc_q[2]), 64'(end_cyc_q[0] + 1));
    end else begin
      timeout("b2b_events");
    end

    // Full stall: both buffers loaded while the sink refuses
    do_reset();
    out_ready = 1'b0;
    send_frame(mk_frame(31), "stall_a");
    send_frame(mk_frame(32), "stall_b");
    chk("stall_ready", 64'(par_ready), 64'(0));
    chk("stall_valid", 64'(out_valid), 64'(1));
    chk("stall_idx",   64'(out_idx),   64'(0));
    par_data = mk_frame(33); par_valid = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    par_valid = 1'b0;
    chk("stall_ignored", 64'(cap_cnt), 64'(2));
    wait_drained(2, 4'b1111, "stall_drain");
    chk("stall_sb_empty", 64'(sb_q.size()), 64'(0));

    // Reset in the middle of a frame with another frame pending
    do_reset();
    out_ready = 1'b0;
    send_frame(mk_frame(41), "mid_a");
    send_frame(mk_frame(42), "mid_b");
    out_ready = 1'b1;
    t = 0;
    while (out_idx != 6'd30 && t < 200) begin
      @(posedge sys_clk); #1;
      t++;
    end
    if (out_idx != 6'd30) timeout("mid_reach_30");
    do_reset();
    out_ready = 1'b1;
    par_data = mk_frame(0);
    send_frame(par_data, "mid_d");
    chk("mid_d_idx",   64'(out_idx),   64'(0));
    chk("mid_d_data",  64'(out_data),  64'(0));
    chk("mid_d_cnt",   64'(frame_cnt), 64'(0));
    wait_drained(1, 4'b1111, "mid_d_drain");
    chk("mid_d_cnt1",  64'(frame_cnt), 64'(1));

    // Counter wrap from 0xFFFF, preloaded while the block is idle
    do_reset();
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    force dut.frame_cnt_q = 16'hFFFF;
    cnt_base = 16'hFFFF;
    @(posedge sys_clk); #1;
    release dut.frame_cnt_q;
    chk("wrap_preload", 64'(frame_cnt), 64'(16'hFFFF));
    send_frame(mk_frame(51), "wrap_capture");
    wait_drained(1, 4'b1111, "wrap_drain");
    chk("wrap_zero", 64'(frame_cnt), 64'(16'h0000));

    repeat (2) @(posedge sys_clk);
    chk("final_sb_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
